// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared mode encodings and pixel sample type for panel_pattern (gradient mode: PANEL_PATTERN_GRADIENT_EN)
package panel_pkg;

    typedef enum logic [1:0] {
        MODE_STRIPE   = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_SOLID    = 2'd2,
        MODE_GRADIENT = 2'd3
    } panel_mode_t;

    // Default channel width; a block with a different COLOR_W declares its own
    // sample struct with the same field layout.
    localparam int PANEL_COLOR_W = 8;

    typedef struct packed {
        logic [PANEL_COLOR_W-1:0] red;
        logic [PANEL_COLOR_W-1:0] green;
        logic [PANEL_COLOR_W-1:0] blue;
        logic [PANEL_COLOR_W-1:0] alpha;
    } panel_rgba_t;

endpackage

// File: rtl/panel_anim_counter.sv
// rtl/panel_anim_counter.sv - tick divider, directional modulo offset and mode/dir latching
import panel_pkg::*;

module panel_anim_counter #(
    parameter int PERIOD_LOG2 = 3,
    parameter int TICK_DIV    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [1:0]             mode,
    input  logic                   dir,
    output logic [PERIOD_LOG2-1:0] offset,
    output panel_mode_t            act_mode,
    output logic                   act_dir
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Count ticks; on the wrapping tick step the offset in the direction sampled on that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            offset   <= '0;
            act_mode <= MODE_STRIPE;
            act_dir  <= 1'b0;
        end else if (tick) begin
            act_mode <= panel_mode_t'(mode);
            act_dir  <= dir;
            if (div_wrap) begin
                div_cnt <= '0;
                if (dir) begin
                    offset <= offset - PERIOD_LOG2'(1);
                end else begin
                    offset <= offset + PERIOD_LOG2'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/panel_pattern.sv
// rtl/panel_pattern.sv - animated RGBA test-pattern source with valid/ack output register (gradient mode: PANEL_PATTERN_GRADIENT_EN)
import panel_pkg::*;

module panel_pattern #(
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 8,
    parameter int PERIOD_LOG2 = 3,
    parameter int TICK_DIV    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               tick,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic               ack,
    output logic               ready,
    output logic               validOut,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [COLOR_W-1:0] alpha
);

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
        logic [COLOR_W-1:0] alpha;
    } rgba_t;

    localparam logic [COLOR_W-1:0] HALF = COLOR_W'(1) << (COLOR_W - 1);
    localparam logic [COLOR_W-1:0] FULL = '1;

    logic [PERIOD_LOG2-1:0] offset;
    panel_mode_t            act_mode;
    logic                   act_dir;
    logic [COORD_W-1:0]     p;
    logic [COLOR_W-1:0]     solid;
    logic                   stripe_lit;
    logic                   checker_lit;
    logic                   accept;
    rgba_t                  pix;
    rgba_t                  sample;

    panel_anim_counter #(
        .PERIOD_LOG2 (PERIOD_LOG2),
        .TICK_DIV    (TICK_DIV)
    ) u_anim (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .mode     (mode),
        .dir      (dir),
        .offset   (offset),
        .act_mode (act_mode),
        .act_dir  (act_dir)
    );

    assign ready  = !validOut || ack;
    assign accept = valid && ready && !tick;

    assign p           = x + COORD_W'(offset);
    assign stripe_lit  = (p[PERIOD_LOG2-1:0] == '0);
    assign checker_lit = p[PERIOD_LOG2] ^ y[PERIOD_LOG2];

    // Offset left-aligned into a colour channel: pad LSBs or drop offset LSBs.
    generate
        if (PERIOD_LOG2 < COLOR_W) begin : g_solid_pad
            assign solid = COLOR_W'(offset) << (COLOR_W - PERIOD_LOG2);
        end else if (PERIOD_LOG2 == COLOR_W) begin : g_solid_eq
            assign solid = offset;
        end else begin : g_solid_trunc
            assign solid = offset[PERIOD_LOG2-1 -: COLOR_W];
        end
    endgenerate

    // Pattern function for the currently latched mode.
    always_comb begin
        pix = '0;
        case (act_mode)
            MODE_CHECKER: begin
                if (checker_lit) begin
                    pix = '{red: HALF, green: HALF, blue: HALF, alpha: FULL};
                end
            end
            MODE_SOLID: begin
                pix = '{red: solid, green: solid, blue: solid, alpha: FULL};
            end
`ifdef PANEL_PATTERN_GRADIENT_EN
            MODE_GRADIENT: begin
                pix = '{red: COLOR_W'(p), green: COLOR_W'(y), blue: '0, alpha: FULL};
            end
`endif
            default: begin
                if (stripe_lit) begin
                    pix = '{red: HALF, green: '0, blue: '0, alpha: FULL};
                end
            end
        endcase
    end

    // Output register loads only on acceptance and otherwise holds for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validOut <= 1'b0;
            sample   <= '0;
        end else if (accept) begin
            validOut <= 1'b1;
            sample   <= pix;
        end else if (ack) begin
            validOut <= 1'b0;
        end
    end

    assign red   = sample.red;
    assign green = sample.green;
    assign blue  = sample.blue;
    assign alpha = sample.alpha;

endmodule

// File: tb/tb_panel_pattern.sv
// tb/tb_panel_pattern.sv - randomized self-checking bench for panel_pattern against a behavioural model
module tb_panel_pattern;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       tick = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [1:0] mode = '0;
    logic       dir = 1'b0;
    logic       ack = 1'b0;

    logic       ready_a, vo_a, ready_b, vo_b;
    logic [7:0] r_a, g_a, b_a, a_a, r_b, g_b, b_b, a_b;

    int n_cmp = 0;
    int n_err = 0;

    // model state: index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=3
    int          m_off [2];
    int          m_div [2];
    int          m_tdiv [2] = '{1, 3};
    bit          m_vo [2];
    logic [31:0] m_pix [2];
    int          m_mode;

    always #5 clk = ~clk;

    panel_pattern dut_a (
        .clk(clk), .rst_n(rst_n), .valid(valid), .tick(tick), .x(x), .y(y),
        .mode(mode), .dir(dir), .ack(ack), .ready(ready_a), .validOut(vo_a),
        .red(r_a), .green(g_a), .blue(b_a), .alpha(a_a)
    );

    panel_pattern #(.TICK_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid(valid), .tick(tick), .x(x), .y(y),
        .mode(mode), .dir(dir), .ack(ack), .ready(ready_b), .validOut(vo_b),
        .red(r_b), .green(g_b), .blue(b_b), .alpha(a_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pix(int px, int py, int md, int off);
        int p;
        int s;
        p = (px + off) % 1024;
        s = off * 32;
        case (md)
            1: return ((((p / 8) % 2) != ((py / 8) % 2))) ? 32'h808080FF : 32'h0;
            2: return {s[7:0], s[7:0], s[7:0], 8'hFF};
`ifdef PANEL_PATTERN_GRADIENT_EN
            3: return {p[7:0], py[7:0], 8'h00, 8'hFF};
`endif
            default: return ((p % 8) == 0) ? 32'h800000FF : 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_off[i] = 0; m_div[i] = 0; m_vo[i] = 0; m_pix[i] = '0;
        end
        m_mode = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_vo_a"},  {31'd0, vo_a}, {31'd0, m_vo[0]});
        chk({tag, "_pix_a"}, {r_a, g_a, b_a, a_a}, m_pix[0]);
        chk({tag, "_rdy_a"}, {31'd0, ready_a}, {31'd0, (!m_vo[0] || ack)});
        chk({tag, "_vo_b"},  {31'd0, vo_b}, {31'd0, m_vo[1]});
        chk({tag, "_pix_b"}, {r_b, g_b, b_b, a_b}, m_pix[1]);
    endtask

    // Advance model with the currently driven inputs, clock once, then compare.
    task automatic cycle(input string tag);
        bit acc;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                acc = valid && (!m_vo[i] || ack) && !tick;
                if (acc) begin
                    m_pix[i] = model_pix(int'(x), int'(y), m_mode, m_off[i]);
                    m_vo[i]  = 1;
                end else if (ack) begin
                    m_vo[i] = 0;
                end
                if (tick) begin
                    m_div[i] = (m_div[i] + 1) % m_tdiv[i];
                    if (m_div[i] == 0) m_off[i] = dir ? (m_off[i] + 7) % 8 : (m_off[i] + 1) % 8;
                end
            end
            if (tick) m_mode = int'(mode);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input int xx, input int yy, input bit a, input bit t,
                         input int md, input bit d);
        valid = v; x = 10'(xx); y = 10'(yy); ack = a; tick = t; mode = 2'(md); dir = d;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // stripe at offset 0
        drive(1, 8, 0, 1, 0, 0, 0); cycle("x8");
        chk("x8_const", {r_a, g_a, b_a, a_a}, 32'h800000FF);
        drive(1, 9, 0, 1, 0, 0, 0); cycle("x9");
        chk("x9_const", {r_a, g_a, b_a, a_a}, 32'h0);

        // one tick then x=7 lit; tick cycle accepts nothing
        drive(1, 3, 0, 1, 1, 0, 0); cycle("tick1");
        drive(1, 7, 0, 1, 0, 0, 0); cycle("x7");
        chk("x7_const", {r_a, g_a, b_a, a_a}, 32'h800000FF);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0); cycle("tick7");
        end
        drive(1, 8, 0, 1, 0, 0, 0); cycle("wrap_x8");
        chk("wrap_x8_const", {r_a, g_a, b_a, a_a}, 32'h800000FF);

        // backpressure: hold ack low, valid ignored, then ack+valid together
        drive(1, 0, 0, 0, 0, 0, 0); cycle("bp_load");
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0); cycle("bp_hold");
            chk("bp_ready", {31'd0, ready_a}, 32'd0);
        end
        drive(1, 1, 0, 1, 0, 0, 0); cycle("bp_swap");
        chk("bp_swap_const", {vo_a, r_a, g_a, b_a, a_a[7:1]}, {1'b1, 31'h0});

        // tick while held: sample unchanged, offset advances
        drive(1, 0, 0, 0, 0, 0, 0); cycle("held_load");
        drive(0, 0, 0, 0, 1, 0, 0); cycle("held_tick");

        // decrement from offset: dir=1 ticks, solid mode shows offset
        drive(0, 0, 0, 1, 1, 2, 1); cycle("dec_tick");
        drive(1, 0, 0, 1, 0, 2, 1); cycle("solid");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1, 2, 1); cycle("dec_tick_n");
            drive(1, 5, 5, 1, 0, 2, 1); cycle("solid_n");
        end

        // mid-frame mode change has no effect until the next tick
        drive(0, 0, 0, 1, 1, 1, 0); cycle("to_chk");
        drive(1, 8, 0, 1, 0, 0, 0); cycle("chk_a");
        drive(1, 8, 8, 1, 0, 0, 0); cycle("chk_b");
        drive(1, 8, 0, 1, 0, 3, 0); cycle("chk_c");

        // mode 3
        drive(0, 0, 0, 1, 1, 3, 0); cycle("to_m3");
        drive(1, 18, 52, 1, 0, 3, 0); cycle("m3");

        // asynchronous reset while holding a sample
        drive(1, 8, 0, 0, 0, 2, 0); cycle("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle("in_rst");
        rst_n = 1'b1;
        drive(1, 8, 0, 1, 0, 0, 0); cycle("post_rst");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int xx;
            xx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 1023));
            drive($urandom_range(0, 3) != 0, xx, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
